// File: rtl/mul_div_if.sv
// Handshake and operand/result bundle between the execute-stage stall logic
// and the iterative multiply/divide unit.
interface mul_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, rs_val, rt_val,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS32 MULT/MULTU/DIV/DIVU unit: one bit per cycle on operand
// magnitudes, sign correction and HI/LO write in a final fix-up cycle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   mul_div_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc;      // product high half / partial remainder
   logic [WIDTH-1:0] q;        // product low half / dividend shifting into quotient
   logic [WIDTH-1:0] b;        // multiplicand / divisor magnitude
   logic [WIDTH-1:0] rs_orig;
   logic             is_div, neg_q, neg_r, dbz;

   logic             busy_r, done_r, dbz_r;
   logic [WIDTH-1:0] hi_r, lo_r;

   logic             rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   always_comb begin
      rs_neg    = bus.op[0] & bus.rs_val[WIDTH-1];
      rt_neg    = bus.op[0] & bus.rt_val[WIDTH-1];
      // Negating the most negative value yields 2^(W-1), the correct unsigned magnitude.
      rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
      rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;

      mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
      div_shift = {acc, q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b};

      prod      = {acc, q};
      prod_fix  = neg_q ? -prod : prod;
      quo_fix   = neg_q ? -q : q;
      rem_fix   = neg_r ? -acc : acc;
   end

   // NOTE: every register here is updated with <= so all reads in this block
   // see the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         q       <= '0;
         b       <= '0;
         rs_orig <= '0;
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dbz     <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         dbz_r   <= 1'b0;
         hi_r    <= '0;
         lo_r    <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state   <= RUN;
                  busy_r  <= 1'b1;
                  count   <= '0;
                  acc     <= '0;
                  q       <= rs_mag;
                  b       <= rt_mag;
                  rs_orig <= bus.rs_val;
                  is_div  <= bus.op[1];
                  neg_q   <= rs_neg ^ rt_neg;
                  neg_r   <= rs_neg;
                  dbz     <= bus.op[1] && (bus.rt_val == '0);
               end
            end
            RUN: begin
               if (is_div) begin
                  // Restoring step: keep the trial difference only when it did not borrow.
                  if (!div_diff[WIDTH]) begin
                     acc <= div_diff[WIDTH-1:0];
                     q   <= {q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= div_shift[WIDTH-1:0];
                     q   <= {q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= mul_sum[WIDTH:1];
                  q   <= {mul_sum[0], q[WIDTH-1:1]};
               end
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
               dbz_r  <= dbz;
               if (!is_div) begin
                  {hi_r, lo_r} <= prod_fix;
               end else if (dbz) begin
                  hi_r <= rs_orig;
                  lo_r <= '1;
               end else begin
                  hi_r <= rem_fix;
                  lo_r <= quo_fix;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;
   assign bus.div_by_zero = dbz_r;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multi-cycle multiply/divide unit for the MIPS32 execute stage, implementing MULT, MULTU, DIV and DIVU into HI/LO result registers. It sits directly upstream of the 32-bit 2:1 writeback-select mux. That mux chooses between the ALU result and this unit's HI or LO output (MFHI/MFLO path). Uses a one-bit-per-cycle shift-add / restoring-divide datapath with a start/busy/done handshake to the pipeline stall logic.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each, iteration count = WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a new operation; sampled only when not busy
op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
rs_val  input  WIDTH  multiplicand / dividend
rt_val  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress; pipeline stalls MFHI/MFLO and new MULT/DIV while high
done  output  1  one-cycle pulse: hi/lo updated this cycle
hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient
div_by_zero  output  1  valid with done; 1 if DIV/DIVU with rt_val==0

Behaviour:
- Reset: one clock is used; reset is synchronous and active-low. While rst_n=0 at a clock edge, the state goes to IDLE and busy=0, done=0, hi=0, lo=0, div_by_zero=0. Internal counter and accumulators are cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, runs exactly WIDTH cycles.
  - FIX: busy=1, one cycle for sign correction and result write.
  - Transitions: IDLE --start--> RUN; RUN --count==WIDTH-1--> FIX; FIX --> IDLE with done=1 in the following cycle.
- Latency: start sampled at edge T0. busy is high for cycles T0+1 .. T0+WIDTH+1. hi/lo/done/div_by_zero update at edge T0+WIDTH+2, so done is high during cycle T0+WIDTH+2 (34 cycles for WIDTH=32).
- done: high for exactly one cycle. busy=0 during the done cycle. A start in the done cycle is accepted (back-to-back operation; done still drops next cycle).
- start while busy=1: ignored, and operands are not latched. Operands and op are latched only at accept; later changes to the inputs have no effect.
- Signed ops (MULT, DIV): compute on absolute values as unsigned WIDTH-bit magnitudes (|-2^(W-1)| = 2^(W-1) unsigned), then negate in FIX.
  - MULT: negate the 2W-bit product if the operand signs differ.
  - DIV: quotient is negated if the signs differ. The remainder takes the sign of the dividend.
- Unsigned ops: no sign correction.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- Divide by zero: still takes the full latency. Result is lo=all ones, hi=rs_val (original, uncorrected), div_by_zero=1 with done.
- div_by_zero is 0 for all multiplies. It holds its value with hi/lo until the next completion.
- hi/lo hold their value between completions; intermediate values never appear on hi/lo.
- Reset mid-operation aborts: hi/lo return to 0 and no done pulse is produced.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> at T0+34: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV rs=0xFFFFFFF9 (-7), rt=2 issued in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, second done exactly 34 cycles after the first.
- DIVU rs=100, rt=0 -> done with div_by_zero=1, hi=0x00000064, lo=0xFFFFFFFF. Then DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Start MULTU 6*7; at cycle T0+5 pulse start with op=DIVU, rs=1, rt=1 and change rs_val -> ignored; result hi=0, lo=42, exactly one done pulse.
- Start DIVU 50/5; drive rst_n=0 at cycle T0+10 -> next cycle busy=0, done=0, hi=lo=0. No done pulse within 40 cycles after rst_n returns to 1.
